i2c_slave_mb: RTL and testbench
===============================

I2C_SLAVE_MB -- requirements
Module: i2c_slave_mb

Interface
REQ-001 NUM_I2C_BUSSES, default 1: number of I2C busses the slave can attach to.
REQ-002 SLAVE_ADDR, default 7'h22: 7-bit address the slave answers to.
REQ-003 MEM_DEPTH, default 16: byte buffer depth, power of two, minimum 2; PTR_W = log2(MEM_DEPTH).
REQ-004 clk_i  in  1  system clock; the block has one clock and all state is on its rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 bus_sel_i  in  max(1,log2(NUM_I2C_BUSSES))  selects the active bus.
REQ-007 scl_i  in  NUM_I2C_BUSSES  I2C clock inputs, asynchronous.
REQ-008 sda_i  in  NUM_I2C_BUSSES  I2C data inputs, asynchronous.
REQ-009 sda_o  out  NUM_I2C_BUSSES  open-drain data drive: 0 pulls low, 1 releases.
REQ-010 busy_o  out  1  high from an accepted START until the following STOP.
REQ-011 wr_stb_o  out  1  one-cycle pulse when a written data byte is stored.
REQ-012 wr_data_o  out  8  byte stored at the last wr_stb_o.
REQ-013 ptr_o  out  PTR_W  current buffer pointer.
REQ-014 done_o  out  1  one-cycle pulse on STOP ending an addressed transfer.

Function
REQ-015 scl_i and sda_i of the selected bus pass through 2-FF synchronisers plus one history register; all edge and START/STOP detection uses the synchronised values.
REQ-016 bus_sel_i is latched only in IDLE; changes during a transfer are ignored until the FSM returns to IDLE.
REQ-017 Unselected busses always get sda_o = 1.
REQ-018 START is a synchronised SDA fall while SCL is high; STOP is a synchronised SDA rise while SCL is high.
REQ-019 FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-020 START in any state, including a repeated START, goes to ADDR, clears the bit counter, sets ptr to 0, and sets busy_o.
REQ-021 STOP in any state goes to IDLE, releases sda_o, and clears busy_o; done_o pulses if the transfer had been addressed.
REQ-022 Bits are sampled on the synchronised SCL rise, MSB first; the 8-bit shift register fills in 8 rises.
REQ-023 After the 8th ADDR bit: if addr[7:1] == SLAVE_ADDR, go to ADDR_ACK; otherwise go to IGNORE, where sda_o stays 1.
REQ-024 ACK drive: sda_o goes 0 on the first cycle after the SCL fall that follows bit 8, and is released on the first cycle after the SCL fall that follows bit 9.
REQ-025 ADDR_ACK exits to WR_DATA if the R/W bit is 0, or to RD_DATA if it is 1.
REQ-026 WR_DATA: after 8 bits, store the byte at mem[ptr], put it on wr_data_o, pulse wr_stb_o in the same cycle, increment ptr, go to WR_ACK (slave ACKs), then return to WR_DATA.
REQ-027 RD_DATA: the MSB of mem[ptr] is driven after the SCL fall that ends the ACK; each subsequent bit is driven after each SCL fall; after the 8th bit sda_o is released and ptr increments.
REQ-028 RD_ACK: the master bit is sampled on the 9th rise; 0 (ACK) returns to RD_DATA, 1 (NACK) goes to IGNORE.
REQ-029 ptr wraps modulo MEM_DEPTH, for example 15 -> 0 when MEM_DEPTH = 16.
REQ-030 A START or STOP in the same cycle as an SCL edge takes precedence over bit sampling.
REQ-031 Buffer contents are not cleared by START or STOP.

Reset
REQ-032 While rst_i is high: state = IDLE, sda_o = all 1s, busy_o = 0, wr_stb_o = 0, done_o = 0, wr_data_o = 0, ptr_o = 0, synchronisers = 1, latched bus = 0, buffer cleared to 0.
REQ-033 Reset asserted mid-transfer releases SDA on the same edge as the assertion, with no glitch low.
REQ-034 After reset releases, the block ignores bus activity until the next valid START.

Verification
REQ-035 Write test: bus 0, START, 0x44, 0xA5, 0x3C, STOP -> three ACKs; wr_stb_o pulses with 0xA5 then 0x3C; ptr_o = 2; done_o pulses once.
REQ-036 Read test: after REQ-035, START, 0x45, read 2 bytes (ACK, then NACK), STOP -> bytes 0xA5 and 0x3C are returned; SDA is released after the NACK.
REQ-037 Wrong address: START, 0x50, 0xFF, STOP -> no ACK; sda_o stays all 1s; no wr_stb_o pulse; done_o stays low.
REQ-038 Wrap test: with MEM_DEPTH = 16, write 17 bytes 0x00..0x10 -> ptr_o = 1 and mem[0] = 0x10.
REQ-039 Multi-bus test: with NUM_I2C_BUSSES = 4 and bus_sel_i = 2, a transfer on bus 1 is ignored and a transfer on bus 2 is ACKed; changing bus_sel_i mid-transfer has no effect.
REQ-040 Reset and repeated START: assert rst_i during the 4th data bit -> sda_o = 1 immediately; a repeated START mid-write resets ptr to 0.

Source files
------------

// File: rtl/i2c_slave_mb.sv
// rtl/i2c_slave_mb.sv - multi-bus I2C slave with a small write/read byte buffer
module i2c_slave_mb #(
    parameter int         NUM_I2C_BUSSES = 1,
    parameter logic [6:0] SLAVE_ADDR     = 7'h22,
    parameter int         MEM_DEPTH      = 16,
    localparam int        PTR_W          = $clog2(MEM_DEPTH),
    localparam int        SEL_W          = (NUM_I2C_BUSSES > 1) ? $clog2(NUM_I2C_BUSSES) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [SEL_W-1:0]          bus_sel_i,
    input  logic [NUM_I2C_BUSSES-1:0] scl_i,
    input  logic [NUM_I2C_BUSSES-1:0] sda_i,
    output logic [NUM_I2C_BUSSES-1:0] sda_o,
    output logic                      busy_o,
    output logic                      wr_stb_o,
    output logic [7:0]                wr_data_o,
    output logic [PTR_W-1:0]          ptr_o,
    output logic                      done_o
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WR_DATA,
        ST_WR_ACK, ST_RD_DATA, ST_RD_ACK, ST_IGNORE
    } state_t;

    state_t           state, state_n;
    logic [SEL_W-1:0] bus_q;
    logic             scl_sel, sda_sel;
    logic [2:0]       scl_sync, sda_sync;   // [1:0] synchroniser, [2] history
    logic [6:0]       shift_q;              // the 8th bit goes straight to its consumer
    logic [7:0]       shift_n;
    logic [2:0]       cnt_q;
    logic [PTR_W-1:0] ptr_q;
    logic             sda_q;
    logic             ack_on_q;
    logic             ack_seen_q;
    logic             addressed_q;
    logic [7:0]       mem [MEM_DEPTH];
    logic [7:0]       rd_byte;

    logic scl_rise, scl_fall, start_det, stop_det, sda_bit, addr_match;

    assign scl_rise   = scl_sync[1] & ~scl_sync[2];
    assign scl_fall   = ~scl_sync[1] & scl_sync[2];
    assign start_det  = scl_sync[1] & sda_sync[2] & ~sda_sync[1];
    assign stop_det   = scl_sync[1] & ~sda_sync[2] & sda_sync[1];
    assign sda_bit    = sda_sync[1];
    assign shift_n    = {shift_q, sda_bit};
    assign addr_match = (shift_n[7:1] == SLAVE_ADDR);
    assign rd_byte    = mem[ptr_q];
    assign ptr_o      = ptr_q;

    // Route the latched bus into the synchroniser; unselected lines idle high
    always_comb begin
        scl_sel = 1'b1;
        sda_sel = 1'b1;
        for (int i = 0; i < NUM_I2C_BUSSES; i++) begin
            if (bus_q == SEL_W'(i)) begin
                scl_sel = scl_i[i];
                sda_sel = sda_i[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_I2C_BUSSES; g++) begin : g_sda
        assign sda_o[g] = (bus_q == SEL_W'(g)) ? sda_q : 1'b1;
    end

    // Bus selection only follows bus_sel_i between transfers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            bus_q <= '0;
        else if (state == ST_IDLE)
            bus_q <= bus_sel_i;
    end

    // Two-flop synchronisers plus one history stage for edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync <= 3'b111;
            sda_sync <= 3'b111;
        end else begin
            scl_sync <= {scl_sync[1:0], scl_sel};
            sda_sync <= {sda_sync[1:0], sda_sel};
        end
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    // Next state: START/STOP override any bit-level progress
    always_comb begin
        state_n = state;
        if (start_det) begin
            state_n = ST_ADDR;
        end else if (stop_det) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_ADDR:     if (scl_rise && cnt_q == 3'd7)
                                 state_n = addr_match ? ST_ADDR_ACK : ST_IGNORE;
                ST_ADDR_ACK: if (scl_fall && ack_on_q)
                                 state_n = shift_q[0] ? ST_RD_DATA : ST_WR_DATA;
                ST_WR_DATA:  if (scl_rise && cnt_q == 3'd7) state_n = ST_WR_ACK;
                ST_WR_ACK:   if (scl_fall && ack_on_q) state_n = ST_WR_DATA;
                ST_RD_DATA:  if (scl_fall && cnt_q == 3'd7) state_n = ST_RD_ACK;
                ST_RD_ACK: begin
                    if (scl_rise && sda_bit)
                        state_n = ST_IGNORE;
                    else if (scl_fall && ack_seen_q)
                        state_n = ST_RD_DATA;
                end
                default: ;
            endcase
        end
    end

    // Datapath: shift/count, SDA drive, buffer, pointer and status pulses
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q     <= '0;
            cnt_q       <= '0;
            ptr_q       <= '0;
            sda_q       <= 1'b1;
            ack_on_q    <= 1'b0;
            ack_seen_q  <= 1'b0;
            addressed_q <= 1'b0;
            busy_o      <= 1'b0;
            wr_stb_o    <= 1'b0;
            wr_data_o   <= '0;
            done_o      <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else begin
            wr_stb_o <= 1'b0;
            done_o   <= 1'b0;
            if (start_det) begin
                cnt_q    <= '0;
                ptr_q    <= '0;
                sda_q    <= 1'b1;
                ack_on_q <= 1'b0;
                busy_o   <= 1'b1;
            end else if (stop_det) begin
                sda_q       <= 1'b1;
                busy_o      <= 1'b0;
                done_o      <= addressed_q;
                addressed_q <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: if (scl_rise) begin
                        shift_q  <= shift_n[6:0];
                        cnt_q    <= cnt_q + 3'd1;
                        ack_on_q <= 1'b0;
                        if (cnt_q == 3'd7 && addr_match) addressed_q <= 1'b1;
                    end
                    ST_ADDR_ACK, ST_WR_ACK: if (scl_fall) begin
                        if (!ack_on_q) begin
                            sda_q    <= 1'b0;
                            ack_on_q <= 1'b1;
                        end else begin
                            // Reads present their MSB on the fall that ends the ACK
                            sda_q    <= (state == ST_ADDR_ACK && shift_q[0]) ? rd_byte[7] : 1'b1;
                            ack_on_q <= 1'b0;
                            cnt_q    <= '0;
                        end
                    end
                    ST_WR_DATA: if (scl_rise) begin
                        shift_q <= shift_n[6:0];
                        cnt_q   <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            mem[ptr_q] <= shift_n;
                            wr_data_o  <= shift_n;
                            wr_stb_o   <= 1'b1;
                            ptr_q      <= ptr_q + 1'b1;
                            ack_on_q   <= 1'b0;
                        end
                    end
                    ST_RD_DATA: if (scl_fall) begin
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            sda_q      <= 1'b1;
                            ptr_q      <= ptr_q + 1'b1;
                            ack_seen_q <= 1'b0;
                        end else begin
                            sda_q <= rd_byte[3'd6 - cnt_q];
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise && !sda_bit) ack_seen_q <= 1'b1;
                        if (scl_fall && ack_seen_q) begin
                            sda_q <= rd_byte[7];
                            cnt_q <= '0;
                        end
                    end
                    default: sda_q <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_mb.sv
// tb/tb_i2c_slave_mb.sv - directed and randomized bench for i2c_slave_mb
module tb_i2c_slave_mb;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] bus_sel = 2'd0;
    logic [3:0] scl_m = 4'hF;
    logic [3:0] sda_m = 4'hF;
    logic [3:0] sda_line;
    logic [3:0] sda_o;
    logic       busy, wr_stb, done;
    logic [7:0] wr_data;
    logic [3:0] ptr;

    int total = 0;
    int bad   = 0;

    logic [7:0] wr_log [$];
    int         done_cnt = 0;
    int         low_cnt [4] = '{0, 0, 0, 0};
    logic [7:0] model [16];

    assign sda_line = sda_m & sda_o;

    i2c_slave_mb #(.NUM_I2C_BUSSES(4), .SLAVE_ADDR(7'h22), .MEM_DEPTH(16)) dut (
        .clk_i(clk), .rst_i(rst), .bus_sel_i(bus_sel),
        .scl_i(scl_m), .sda_i(sda_line), .sda_o(sda_o),
        .busy_o(busy), .wr_stb_o(wr_stb), .wr_data_o(wr_data),
        .ptr_o(ptr), .done_o(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_stb) wr_log.push_back(wr_data);
        if (done) done_cnt++;
        for (int i = 0; i < 4; i++) if (!sda_o[i]) low_cnt[i]++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start(input int b);
        sda_m[b] = 1'b1; hold();
        scl_m[b] = 1'b1; hold();
        sda_m[b] = 1'b0; hold();
        scl_m[b] = 1'b0; hold();
    endtask

    task automatic i2c_stop(input int b);
        sda_m[b] = 1'b0; hold();
        scl_m[b] = 1'b1; hold();
        sda_m[b] = 1'b1; hold();
    endtask

    task automatic clk_bit(input int b, input logic v, output logic s);
        sda_m[b] = v; hold();
        scl_m[b] = 1'b1; hold();
        s = sda_line[b]; hold();
        scl_m[b] = 1'b0; hold();
    endtask

    task automatic write_byte(input int b, input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b, d[i], s);
        clk_bit(b, 1'b1, ack);
    endtask

    task automatic read_byte(input int b, input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(b, 1'b1, s);
            d[i] = s;
        end
        clk_bit(b, nack, s);
    endtask

    task automatic wr_bytes(input int b, input logic [7:0] data [$]);
        logic ack;
        int   wn, dn;
        wn = wr_log.size();
        dn = done_cnt;
        i2c_start(b);
        chk("wr_busy", busy, 1);
        write_byte(b, 8'h44, ack);
        chk("wr_addr_ack", ack, 0);
        foreach (data[i]) begin
            write_byte(b, data[i], ack);
            chk("wr_data_ack", ack, 0);
            model[i % 16] = data[i];
        end
        i2c_stop(b);
        chk("wr_stb_count", wr_log.size(), wn + data.size());
        foreach (data[i]) chk("wr_stb_data", wr_log[wn + i], data[i]);
        chk("wr_ptr", ptr, data.size() % 16);
        chk("wr_done", done_cnt, dn + 1);
        chk("wr_idle", busy, 0);
    endtask

    task automatic rd_bytes(input int b, input int n);
        logic       ack;
        logic [7:0] d;
        i2c_start(b);
        write_byte(b, 8'h45, ack);
        chk("rd_addr_ack", ack, 0);
        for (int i = 0; i < n; i++) begin
            read_byte(b, (i == n - 1), d);
            chk("rd_data", d, model[i % 16]);
        end
        chk("rd_release", sda_o[b], 1);
        chk("rd_ptr", ptr, n % 16);
        i2c_stop(b);
    endtask

    initial begin
        logic [7:0] q [$];
        logic [7:0] d, b1, b2, b3;
        logic       ack, s;
        int         wn, dn, lc, n;

        for (int i = 0; i < 16; i++) model[i] = 8'h00;

        // Reset state
        repeat (5) @(negedge clk);
        chk("rst_sda", sda_o, 4'hF);
        chk("rst_busy", busy, 0);
        chk("rst_stb", wr_stb, 0);
        chk("rst_done", done, 0);
        chk("rst_wdata", wr_data, 0);
        chk("rst_ptr", ptr, 0);
        rst = 1'b0;
        hold();

        // Basic write then read-back on bus 0
        q = '{8'hA5, 8'h3C};
        wr_bytes(0, q);
        rd_bytes(0, 2);

        // Wrong address is ignored entirely
        wn = wr_log.size(); dn = done_cnt; lc = low_cnt[0];
        i2c_start(0);
        write_byte(0, 8'h50, ack);
        chk("bad_addr_ack", ack, 1);
        write_byte(0, 8'hFF, ack);
        chk("bad_data_ack", ack, 1);
        i2c_stop(0);
        chk("bad_low", low_cnt[0], lc);
        chk("bad_stb", wr_log.size(), wn);
        chk("bad_done", done_cnt, dn);

        // Random write bursts with read-back
        repeat (3) begin
            n = $urandom_range(1, 5);
            q = {};
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            wr_bytes(0, q);
            rd_bytes(0, n);
        end

        // Pointer wrap: 17 bytes into a 16-deep buffer
        q = {};
        for (int i = 0; i < 17; i++) q.push_back(8'(i));
        wr_bytes(0, q);
        rd_bytes(0, 1);

        // Multi-bus: only the latched bus is served
        bus_sel = 2'd2;
        hold(); hold();
        wn = wr_log.size(); dn = done_cnt; lc = low_cnt[1];
        i2c_start(1);
        write_byte(1, 8'h44, ack);
        chk("bus1_addr_ack", ack, 1);
        write_byte(1, 8'h77, ack);
        chk("bus1_data_ack", ack, 1);
        i2c_stop(1);
        chk("bus1_stb", wr_log.size(), wn);
        chk("bus1_done", done_cnt, dn);
        b1 = 8'($urandom);
        i2c_start(2);
        write_byte(2, 8'h44, ack);
        chk("bus2_addr_ack", ack, 0);
        bus_sel = 2'd1;
        write_byte(2, b1, ack);
        chk("bus2_data_ack", ack, 0);
        i2c_stop(2);
        model[0] = b1;
        chk("bus2_stb", wr_log.size(), wn + 1);
        chk("bus2_data", wr_log[wn], b1);
        chk("bus2_done", done_cnt, dn + 1);
        chk("bus1_never_low", low_cnt[1], lc);
        chk("bus2_ptr", ptr, 1);
        bus_sel = 2'd0;
        hold(); hold();

        // Reset while the slave drives the 4th bit of a read byte
        q = '{8'h00};
        wr_bytes(0, q);
        i2c_start(0);
        write_byte(0, 8'h45, ack);
        chk("rst_rd_ack", ack, 0);
        for (int i = 0; i < 3; i++) clk_bit(0, 1'b1, s);
        sda_m[0] = 1'b1; hold();
        chk("rst_pre_drive", sda_o[0], 0);
        @(negedge clk); #2 rst = 1'b1;
        #1;
        chk("rst_async_sda", sda_o, 4'hF);
        chk("rst_async_busy", busy, 0);
        hold();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        hold();
        chk("rst_ptr_after", ptr, 0);
        // Bits without a START must be ignored
        lc = low_cnt[0];
        write_byte(0, 8'h44, ack);
        chk("nostart_ack", ack, 1);
        chk("nostart_low", low_cnt[0], lc);
        chk("nostart_busy", busy, 0);
        i2c_stop(0);
        rd_bytes(0, 2);

        // Repeated START in the middle of a write
        b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
        wn = wr_log.size(); dn = done_cnt;
        i2c_start(0);
        write_byte(0, 8'h44, ack);
        chk("rs_addr_ack", ack, 0);
        write_byte(0, b1, ack);
        write_byte(0, b2, ack);
        chk("rs_ptr_before", ptr, 2);
        i2c_start(0);
        chk("rs_ptr_cleared", ptr, 0);
        chk("rs_busy", busy, 1);
        write_byte(0, 8'h44, ack);
        chk("rs_addr2_ack", ack, 0);
        write_byte(0, b3, ack);
        i2c_stop(0);
        model[0] = b3; model[1] = b2;
        chk("rs_ptr_after", ptr, 1);
        chk("rs_stb", wr_log.size(), wn + 3);
        chk("rs_done", done_cnt, dn + 1);
        rd_bytes(0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
